// File: rtl/button_trigger_pkg.sv
// Shared encodings and board defaults for the button front end and the burst generator test top.
package button_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_ILLEGAL = 2'b10,
        ST_CLEAR   = 2'b11
    } state_t;

    localparam int DEB_W_BOARD    = 20;
    localparam int DEB_CNT_BOARD  = 1000000;
    localparam int CLR_HOLD_BOARD = 4;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser, stable-count debouncer and rising-edge detect for one raw button.
// deb follows a stable input DEB_CNT+2 cycles after it is first sampled; no flow control.
module debouncer #(
    parameter int DEB_W   = 20,
    parameter int DEB_CNT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic deb,
    output logic rise
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_dly_q;
    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            // Any sample agreeing with the current level restarts the stability count.
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign deb  = deb_q;
    assign rise = deb_q & ~deb_dly_q;

endmodule

// File: rtl/button_trigger.sv
// Turns debounced RUN/CLEAR presses into the burst generator's trigger level plus LED status.
// Outputs react one cycle after a debounced rise (DEB_CNT+3 from the raw edge); no flow control.
module button_trigger
    import button_trigger_pkg::*;
#(
    parameter int DEB_W    = DEB_W_BOARD,
    parameter int DEB_CNT  = DEB_CNT_BOARD,
    parameter int CLR_HOLD = CLR_HOLD_BOARD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_clr,
    output logic       trigger,
    output logic       run_pulse,
    output logic [7:0] burst_cnt,
    output logic [1:0] state
);

    localparam int                HOLD_W    = $clog2(CLR_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLR_HOLD - 1);

    logic run_deb;
    logic run_rise;
    logic clr_deb;
    logic clr_rise;

    // Debounced levels stay as named nets for probing; the FSM acts on edges only.
    logic [1:0] deb_unused;
    assign deb_unused = {run_deb, clr_deb};

    debouncer #(.DEB_W(DEB_W), .DEB_CNT(DEB_CNT)) u_deb_run (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_run),
        .deb  (run_deb),
        .rise (run_rise)
    );

    debouncer #(.DEB_W(DEB_W), .DEB_CNT(DEB_CNT)) u_deb_clr (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_clr),
        .deb  (clr_deb),
        .rise (clr_rise)
    );

    state_t            state_q;
    logic              trigger_q;
    logic              run_pulse_q;
    logic [7:0]        burst_cnt_q;
    logic [HOLD_W-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            trigger_q   <= 1'b0;
            run_pulse_q <= 1'b0;
            burst_cnt_q <= 8'd0;
            hold_q      <= '0;
        end else begin
            run_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Clear has priority when both presses land on the same cycle.
                    if (clr_rise) begin
                        state_q   <= ST_CLEAR;
                        trigger_q <= 1'b0;
                        hold_q    <= '0;
                    end else if (run_rise) begin
                        state_q     <= ST_ARMED;
                        trigger_q   <= 1'b1;
                        run_pulse_q <= 1'b1;
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                    end
                end
                ST_ARMED: begin
                    if (clr_rise) begin
                        state_q   <= ST_CLEAR;
                        trigger_q <= 1'b0;
                        hold_q    <= '0;
                    end
                end
                ST_CLEAR: begin
                    // Hold runs to completion regardless of further presses.
                    if (hold_q == HOLD_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    trigger_q <= 1'b0;
                end
            endcase
        end
    end

    assign trigger   = trigger_q;
    assign run_pulse = run_pulse_q;
    assign burst_cnt = burst_cnt_q;
    assign state     = state_q;

endmodule
